// File: rtl/cvbs_syncgen_pkg.sv
// Shared PAL timing defaults, CVBS sample type and level helpers for cvbs_syncgen.
// Also used by the sync-detector bench so both ends agree on the sample format.
package cvbs_syncgen_pkg;

  typedef logic [5:0] cvbs_sample_t;

  localparam int HCOUNT_W        = 11;
  localparam int LINE_W          = 10;

  localparam int LINE_TIME       = 1536;
  localparam int HSYNC_TIME      = 113;
  localparam int BACKPORCH_TIME  = 137;
  localparam int FRONTPORCH_TIME = 38;
  localparam int LINES           = 312;
  localparam int VSYNC_LINES     = 3;
  localparam int FIRST_ACTIVE    = 23;
  localparam int ACTIVE_LINES    = 288;

  localparam cvbs_sample_t SYNC_LEVEL  = 6'd0;
  localparam cvbs_sample_t BLACK_LEVEL = 6'd12;

  // 7-bit add so the carry is visible; clamp to full white instead of wrapping.
  function automatic cvbs_sample_t sat_add(input cvbs_sample_t a, input cvbs_sample_t b);
    logic [6:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[6] ? 6'd63 : sum[5:0];
  endfunction

endpackage

// File: rtl/cvbs_level_mux.sv
// Registered CVBS level select: sync tip, black + luma (saturating) or plain black.
// Looks at the decoded position registered on the previous ce and the luma sampled now.
module cvbs_level_mux
  import cvbs_syncgen_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         ce_i,
  input  logic         sync_low_i,
  input  logic         active_i,
  input  cvbs_sample_t video_i,
  output cvbs_sample_t cvbs_o
);

  cvbs_sample_t cvbs_q, cvbs_d;

  always_comb begin
    cvbs_d = BLACK_LEVEL;
    if (sync_low_i) begin
      cvbs_d = SYNC_LEVEL;
    end else if (active_i) begin
      cvbs_d = sat_add(BLACK_LEVEL, video_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cvbs_q <= BLACK_LEVEL;
    end else if (ce_i) begin
      cvbs_q <= cvbs_d;
    end
  end

  assign cvbs_o = cvbs_q;

endmodule

// File: rtl/cvbs_syncgen.sv
// PAL-rate line/frame timing generator and CVBS sync inserter.
// Build option: define CVBS_SYNCGEN_SERRATION_EN for broad-pulse vertical sync.
module cvbs_syncgen
  import cvbs_syncgen_pkg::*;
#(
  parameter int LINE_TIME_P       = LINE_TIME,
  parameter int HSYNC_TIME_P      = HSYNC_TIME,
  parameter int BACKPORCH_TIME_P  = BACKPORCH_TIME,
  parameter int FRONTPORCH_TIME_P = FRONTPORCH_TIME,
  parameter int LINES_P           = LINES,
  parameter int VSYNC_LINES_P     = VSYNC_LINES,
  parameter int FIRST_ACTIVE_P    = FIRST_ACTIVE,
  parameter int ACTIVE_LINES_P    = ACTIVE_LINES
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  cvbs_sample_t        video,
  output cvbs_sample_t        cvbs,
  output logic                hsync,
  output logic                vsync,
  output logic                porch,
  output logic                active,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [LINE_W-1:0]   line_number
);

  // Video contract: while active=1, upstream holds the luma for that position
  // on video; it is sampled on the next ce, which also emits that position's cvbs.

  logic                started_q, started_d;
  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                porch_q, porch_d;
  logic                active_q, active_d;
  logic                vs_line, vs_hsync, in_tip, in_porch, in_picture, picture_line;

  // The first ce after reset decodes position 0 instead of stepping past it.
  always_comb begin
    started_d = started_q;
    hcount_d  = hcount_q;
    line_d    = line_q;
    if (ce) begin
      started_d = 1'b1;
      if (started_q) begin
        if (hcount_q == HCOUNT_W'(LINE_TIME_P - 1)) begin
          hcount_d = '0;
          line_d   = (line_q == LINE_W'(LINES_P - 1)) ? '0 : line_q + 1'b1;
        end else begin
          hcount_d = hcount_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    vs_line      = line_d < LINE_W'(VSYNC_LINES_P);
    in_tip       = hcount_d < HCOUNT_W'(HSYNC_TIME_P);
    in_porch     = !in_tip && (hcount_d < HCOUNT_W'(HSYNC_TIME_P + BACKPORCH_TIME_P));
    in_picture   = (hcount_d >= HCOUNT_W'(HSYNC_TIME_P + BACKPORCH_TIME_P)) &&
                   (hcount_d <  HCOUNT_W'(LINE_TIME_P - FRONTPORCH_TIME_P));
    picture_line = (line_d >= LINE_W'(FIRST_ACTIVE_P)) &&
                   (line_d <  LINE_W'(FIRST_ACTIVE_P + ACTIVE_LINES_P));
`ifdef CVBS_SYNCGEN_SERRATION_EN
    vs_hsync     = hcount_d >= HCOUNT_W'(LINE_TIME_P - HSYNC_TIME_P);
`else
    vs_hsync     = 1'b0;
`endif
    hsync_d      = vs_line ? vs_hsync : !in_tip;
    vsync_d      = !vs_line;
    porch_d      = !vs_line && in_porch;
    active_d     = !vs_line && in_picture && picture_line;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      started_q <= 1'b0;
      hcount_q  <= '0;
      line_q    <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      porch_q   <= 1'b0;
      active_q  <= 1'b0;
    end else if (ce) begin
      started_q <= started_d;
      hcount_q  <= hcount_d;
      line_q    <= line_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      porch_q   <= porch_d;
      active_q  <= active_d;
    end
  end

  // hsync low is the sync-tip indicator on every line, vsync lines included.
  cvbs_level_mux u_level_mux (
    .clk        (clk),
    .reset      (reset),
    .ce_i       (ce),
    .sync_low_i (!hsync_q),
    .active_i   (active_q),
    .video_i    (video),
    .cvbs_o     (cvbs)
  );

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign porch       = porch_q;
  assign active      = active_q;
  assign hcount      = hcount_q;
  assign line_number = line_q;

endmodule
